label_emitter: RTL and testbench
================================

Name: label_emitter

Overview:
- Reverse direction of the assembler label path: takes a resolved branch/jump (current pc + signed offset) and regenerates the quoted label text as an ASCII character stream, e.g. 'loop'.
- Owns a small label table written with the same packed 5-bit letter format and pc the label parser produces.
- Sits on the disassembler/debug-print path and feeds a character sink (UART TX / text buffer) through a valid/ready handshake.

Parameters:
- NUMBER_LINES, 256, program lines; pc width PW = $clog2(NUMBER_LINES)+2.
- NUMBER_LETTERS, 6, max letters per label.
- NUM_LABELS, 8, table entries.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous, active-high reset.
- label_we  in  1  write one table entry this cycle.
- label_name_in  in  [NUMBER_LETTERS-1:0][4:0]  packed letters, last letter in [0], unused leading slots 0.
- label_pc_in  in  PW  pc of the label.
- req_valid  in  1  emit request.
- req_ready  out  1  high only in IDLE.
- req_pc  in  PW  pc of the referencing instruction.
- req_offset  in  32  signed byte offset; target = req_pc + offset.
- char_out  out  8  ASCII character.
- char_valid  out  1  char_out valid.
- char_ready  in  1  sink accepts.
- done_flag  out  1  one-cycle pulse after closing quote is accepted.
- error_flag  out  1  one-cycle pulse on lookup failure.

Behaviour:
- Reset: char_valid=0, char_out=0, done_flag=0, error_flag=0, state IDLE, all table valid bits cleared. Reset in any state aborts emission the same cycle; no further chars.
- Table: shift register, new entry into slot 0, oldest dropped when full (NUM_LABELS+1 writes evict the first). Writes accepted in any state. The matched name is latched in LOOKUP, so later writes do not alter an emission in progress.
- Target: offset must satisfy offset[31:PW-1] all equal (sign-extends from PW bits), else error. target = (req_pc + offset[PW-1:0]) mod 2^PW.
- Match: lowest-index valid entry with pc == target wins (newest on duplicates).
- FSM: IDLE -> LOOKUP -> OPEN -> LETTERS -> CLOSE -> DONE -> IDLE. LOOKUP -> ERROR -> IDLE on miss or range failure.
- Timing: cycle 0, req_valid && req_ready accepts and registers the request. Cycle 1 is LOOKUP. Cycle 2 drives char_valid=1, char_out=0x27.
- OPEN: hold 0x27 until char_ready. Then go to LETTERS, or to CLOSE if the name is all zero.
- LETTERS: index runs from NUMBER_LETTERS-1 down to 0. Leading zero slots are skipped with no idle cycles: the first letter is presented the cycle after the quote is accepted. Each letter is emitted as {3'b011, code} (lowercase). Advance only on char_valid && char_ready.
- CLOSE: emit 0x27. On acceptance go to DONE.
- DONE: done_flag=1 for one cycle. ERROR: error_flag=1 for one cycle. char_valid=0 in both.
- char_out and char_valid are registered. While char_valid=1 && char_ready=0, char_out holds stable.
- req_valid outside IDLE is ignored (req_ready=0).
- Simultaneous label_we and a LOOKUP whose target matches the entry being written: the lookup sees pre-write contents.

Decomposition:
- Shared constants package: emitter_state_t enum; QUOTE_CHAR=8'h27; LOWER_PREFIX=3'b011.
- Sub-module label_table: storage, valid bits, shift-in write, combinational priority match by pc (hit, name). label_emitter holds the FSM, range check, letter counter and output register.

Test Plan:
- Write "loop" at pc 0x010 (slots [3..0]=0x0C,0x0F,0x0F,0x10). Request pc 0x018, offset -8, char_ready=1 -> chars 0x27,0x6C,0x6F,0x6F,0x70,0x27 on cycles 2-7, done_flag on cycle 8.
- Same request with char_ready low for 3 cycles while 0x6C is presented -> 0x6C stable, char_valid held, sequence otherwise identical, done one cycle per stall later.
- Request target 0x020 with no entry -> no char_valid, error_flag pulse on cycle 2, req_ready high on cycle 3.
- offset 0x0000_1000 (outside 10-bit pc range) -> error_flag, no chars.
- Write "a"@0x004 then "b"@0x004, request target 0x004 -> emits 'b'. Write 9 labels, request the first one's pc -> error.
- Assert rst_in during LETTERS -> next cycle char_valid=0, state IDLE, table empty, so the same request now errors.

Source files
------------

// File: rtl/label_emitter_pkg.sv
// Shared types and constants for the label emitter: FSM state encoding and
// the ASCII framing used when a packed 5-bit label is turned back into text.
package label_emitter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_OPEN,
    ST_LETTERS,
    ST_CLOSE,
    ST_DONE,
    ST_ERROR
  } emitter_state_t;

  localparam logic [7:0] QUOTE_CHAR   = 8'h27;
  localparam logic [2:0] LOWER_PREFIX = 3'b011;

  // 5-bit letter code (a=1 .. z=26) to lowercase ASCII.
  function automatic logic [7:0] letter_char(input logic [4:0] code);
    return {LOWER_PREFIX, code};
  endfunction

endpackage

// File: rtl/label_emitter_table.sv
// Label table: shift-in storage of (name, pc) pairs with a combinational
// lookup that returns the lowest-index (newest) valid entry matching a pc.
module label_table
  import label_emitter_pkg::*;
#(
  parameter int NUMBER_LETTERS = 6,
  parameter int NUM_LABELS     = 8,
  parameter int PW             = 10
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           we_i,
  input  logic [NUMBER_LETTERS-1:0][4:0] wr_name_i,
  input  logic [PW-1:0]                  wr_pc_i,
  input  logic [PW-1:0]                  lookup_pc_i,
  output logic                           hit_o,
  output logic [NUMBER_LETTERS-1:0][4:0] hit_name_o
);

  logic [NUMBER_LETTERS-1:0][4:0] name_q [NUM_LABELS];
  logic [PW-1:0]                  pc_q   [NUM_LABELS];
  logic [NUM_LABELS-1:0]          valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < NUM_LABELS; i++) begin
        name_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (we_i) begin
      for (int unsigned i = NUM_LABELS - 1; i > 0; i--) begin
        name_q[i]  <= name_q[i-1];
        pc_q[i]    <= pc_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
      name_q[0]  <= wr_name_i;
      pc_q[0]    <= wr_pc_i;
      valid_q[0] <= 1'b1;
    end
  end

  // Scan from oldest to newest so the lowest matching index is the last to win.
  always_comb begin
    hit_o      = 1'b0;
    hit_name_o = '0;
    for (int unsigned i = 0; i < NUM_LABELS; i++) begin
      if (valid_q[NUM_LABELS-1-i] && (pc_q[NUM_LABELS-1-i] == lookup_pc_i)) begin
        hit_o      = 1'b1;
        hit_name_o = name_q[NUM_LABELS-1-i];
      end
    end
  end

endmodule

// File: rtl/label_emitter.sv
// Regenerates quoted label text ('name') for a resolved pc+offset target and
// streams it one ASCII character at a time over a valid/ready handshake.
module label_emitter
  import label_emitter_pkg::*;
#(
  parameter  int NUMBER_LINES   = 256,
  parameter  int NUMBER_LETTERS = 6,
  parameter  int NUM_LABELS     = 8,
  localparam int PW             = $clog2(NUMBER_LINES) + 2
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           label_we,
  input  logic [NUMBER_LETTERS-1:0][4:0] label_name_in,
  input  logic [PW-1:0]                  label_pc_in,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [PW-1:0]                  req_pc,
  input  logic [31:0]                    req_offset,
  output logic [7:0]                     char_out,
  output logic                           char_valid,
  input  logic                           char_ready,
  output logic                           done_flag,
  output logic                           error_flag
);

  localparam int IW = (NUMBER_LETTERS > 1) ? $clog2(NUMBER_LETTERS) : 1;

  emitter_state_t                 state_q, state_d;
  logic [PW-1:0]                  req_pc_q, req_pc_d;
  logic [31:0]                    req_off_q, req_off_d;
  logic [NUMBER_LETTERS-1:0][4:0] name_q, name_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [7:0]                     char_out_q, char_out_d;
  logic                           char_valid_q, char_valid_d;
  logic                           done_q, done_d;
  logic                           error_q, error_d;

  logic                           offset_ok;
  logic [PW-1:0]                  target_pc;
  logic                           tbl_hit;
  logic [NUMBER_LETTERS-1:0][4:0] tbl_name;
  logic [IW-1:0]                  first_idx;
  logic                           name_empty;
  logic [IW-1:0]                  idx_dec;

  // Offset must be a sign extension of its low PW bits.
  assign offset_ok = (req_off_q[31:PW-1] == '0) || (req_off_q[31:PW-1] == '1);
  assign target_pc = req_pc_q + req_off_q[PW-1:0];
  assign idx_dec   = idx_q - 1'b1;

  label_table #(
    .NUMBER_LETTERS (NUMBER_LETTERS),
    .NUM_LABELS     (NUM_LABELS),
    .PW             (PW)
  ) u_table (
    .clk_i       (clk_in),
    .rst_i       (rst_in),
    .we_i        (label_we),
    .wr_name_i   (label_name_in),
    .wr_pc_i     (label_pc_in),
    .lookup_pc_i (target_pc),
    .hit_o       (tbl_hit),
    .hit_name_o  (tbl_name)
  );

  // Highest non-zero slot of the latched name: first letter to present.
  always_comb begin
    first_idx  = '0;
    name_empty = 1'b1;
    for (int unsigned i = 0; i < NUMBER_LETTERS; i++) begin
      if (name_q[i] != '0) begin
        first_idx  = IW'(i);
        name_empty = 1'b0;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    req_pc_d     = req_pc_q;
    req_off_d    = req_off_q;
    name_d       = name_q;
    idx_d        = idx_q;
    char_out_d   = char_out_q;
    char_valid_d = char_valid_q;
    done_d       = 1'b0;
    error_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_pc_d  = req_pc;
          req_off_d = req_offset;
          state_d   = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (offset_ok && tbl_hit) begin
          name_d       = tbl_name;
          char_out_d   = QUOTE_CHAR;
          char_valid_d = 1'b1;
          state_d      = ST_OPEN;
        end else begin
          error_d = 1'b1;
          state_d = ST_ERROR;
        end
      end
      ST_OPEN: begin
        if (char_ready) begin
          if (name_empty) begin
            char_out_d = QUOTE_CHAR;
            state_d    = ST_CLOSE;
          end else begin
            idx_d      = first_idx;
            char_out_d = letter_char(name_q[first_idx]);
            state_d    = ST_LETTERS;
          end
        end
      end
      ST_LETTERS: begin
        if (char_ready) begin
          if (idx_q == '0) begin
            char_out_d = QUOTE_CHAR;
            state_d    = ST_CLOSE;
          end else begin
            idx_d      = idx_dec;
            char_out_d = letter_char(name_q[idx_dec]);
          end
        end
      end
      ST_CLOSE: begin
        if (char_ready) begin
          char_valid_d = 1'b0;
          done_d       = 1'b1;
          state_d      = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      req_pc_q     <= '0;
      req_off_q    <= '0;
      name_q       <= '0;
      idx_q        <= '0;
      char_out_q   <= '0;
      char_valid_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_pc_q     <= req_pc_d;
      req_off_q    <= req_off_d;
      name_q       <= name_d;
      idx_q        <= idx_d;
      char_out_q   <= char_out_d;
      char_valid_q <= char_valid_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign char_out   = char_out_q;
  assign char_valid = char_valid_q;
  assign done_flag  = done_q;
  assign error_flag = error_q;

endmodule

// File: tb/tb_label_emitter.sv
// Self-checking bench for label_emitter: directed scenarios plus randomized
// requests checked against a text-level model of the label table.
module tb_label_emitter;

  localparam int NL   = 256;
  localparam int NLET = 6;
  localparam int NLAB = 8;
  localparam int PW   = $clog2(NL) + 2;

  typedef logic [NLET-1:0][4:0] name_t;
  typedef logic [NLET-1:0][7:0] txt_t;
  typedef struct {
    txt_t          txt;
    int            len;
    logic [PW-1:0] pc;
  } ent_t;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          label_we = 1'b0;
  name_t         label_name_in = '0;
  logic [PW-1:0] label_pc_in = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [PW-1:0] req_pc = '0;
  logic [31:0]   req_offset = '0;
  logic [7:0]    char_out;
  logic          char_valid;
  logic          char_ready = 1'b0;
  logic          done_flag;
  logic          error_flag;

  int total = 0;
  int bad   = 0;
  ent_t model[$];

  label_emitter #(
    .NUMBER_LINES   (NL),
    .NUMBER_LETTERS (NLET),
    .NUM_LABELS     (NLAB)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .label_we      (label_we),
    .label_name_in (label_name_in),
    .label_pc_in   (label_pc_in),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_pc        (req_pc),
    .req_offset    (req_offset),
    .char_out      (char_out),
    .char_valid    (char_valid),
    .char_ready    (char_ready),
    .done_flag     (done_flag),
    .error_flag    (error_flag)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic txt_t str2txt(input string s);
    txt_t t = '0;
    for (int i = 0; i < s.len() && i < NLET; i++) t[i] = s[i];
    return t;
  endfunction

  // Drive one table write (committed at the next edge) and mirror it in the model.
  task automatic drive_write(input txt_t txt, input int len, input logic [PW-1:0] pc);
    ent_t  e;
    name_t n = '0;
    for (int k = 0; k < len; k++) n[len-1-k] = txt[k][4:0];
    label_we      = 1'b1;
    label_name_in = n;
    label_pc_in   = pc;
    e.txt = txt; e.len = len; e.pc = pc;
    model.push_front(e);
    if (model.size() > NLAB) void'(model.pop_back());
  endtask

  task automatic write_label(input string s, input logic [PW-1:0] pc);
    drive_write(str2txt(s), s.len(), pc);
    tick();
    label_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
    model.delete();
  endtask

  // Expected character stream for a request, or error when empty-handed.
  task automatic model_expect(input logic [PW-1:0] pc, input logic [31:0] off,
                              output bit err, output logic [7:0] q[$]);
    int so = off;
    int t;
    q.delete();
    err = 1'b1;
    if (so < -(1 << (PW-1)) || so > (1 << (PW-1)) - 1) return;
    t = (int'(pc) + so) & ((1 << PW) - 1);
    foreach (model[i]) begin
      if (int'(model[i].pc) == t) begin
        err = 1'b0;
        q.push_back(8'h27);
        for (int k = 0; k < model[i].len; k++) q.push_back(model[i].txt[k]);
        q.push_back(8'h27);
        break;
      end
    end
  endtask

  // mode 0: always ready; 1: random ready; 2: stall 3 cycles on 'l'.
  task automatic do_req(input logic [PW-1:0] pc, input logic [31:0] off, input int mode,
                        input bit wr_mid, input string wr_s, input logic [PW-1:0] wr_pc);
    bit         err;
    logic [7:0] q[$];
    int         cyc = 1, stalls = 0, held = 0, nchars;
    bit         finished = 1'b0, prev_stall = 1'b0;
    logic [7:0] prev_char = '0;
    model_expect(pc, off, err, q);
    nchars = q.size();
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_pc = pc; req_offset = off;
    tick();
    req_valid = 1'b0;
    chk("lookup_no_valid", char_valid, 0);
    if (wr_mid) drive_write(str2txt(wr_s), wr_s.len(), wr_pc);
    while (!finished && cyc < 300) begin
      tick();
      cyc++;
      label_we = 1'b0;
      if (err) begin
        chk("err_no_char", char_valid, 0);
        if (cyc == 2) begin
          chk("err_flag", error_flag, 1);
          chk("err_no_done", done_flag, 0);
        end else begin
          chk("err_ready_back", req_ready, 1);
          chk("err_flag_pulse", error_flag, 0);
          finished = 1'b1;
        end
      end else if (cyc == 2 || char_valid) begin
        chk("char_valid", char_valid, 1);
        if (q.size() == 0) chk("extra_char", char_out, 0);
        else chk("char", char_out, q[0]);
        if (prev_stall) chk("char_hold", char_out, prev_char);
        case (mode)
          0:       char_ready = 1'b1;
          1:       char_ready = ($urandom_range(0, 3) != 0);
          default: begin
            char_ready = !(char_out == 8'h6C && held < 3);
            if (!char_ready) held++;
          end
        endcase
        prev_stall = !char_ready;
        prev_char  = char_out;
        if (char_ready) begin
          if (q.size() > 0) void'(q.pop_front());
        end else begin
          stalls++;
        end
      end else begin
        chk("done_flag", done_flag, 1);
        chk("done_cycle", cyc, 2 + nchars + stalls);
        chk("chars_left", q.size(), 0);
        chk("no_err", error_flag, 0);
        tick();
        chk("ready_after_done", req_ready, 1);
        chk("done_pulse", done_flag, 0);
        finished = 1'b1;
      end
    end
    if (!finished) chk("timeout", 0, 1);
    char_ready = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_char_valid", char_valid, 0);
    chk("rst_char_out", char_out, 0);
    chk("rst_done", done_flag, 0);
    chk("rst_error", error_flag, 0);
    chk("rst_ready", req_ready, 1);

    write_label("loop", 10'h010);
    do_req(10'h018, 32'hFFFF_FFF8, 0, 1'b0, "", '0);
    do_req(10'h018, 32'hFFFF_FFF8, 2, 1'b0, "", '0);
    do_req(10'h018, 32'h0000_0008, 0, 1'b0, "", '0);
    do_req(10'h018, 32'h0000_1000, 0, 1'b0, "", '0);

    write_label("a", 10'h004);
    write_label("b", 10'h004);
    do_req(10'h000, 32'h0000_0004, 1, 1'b0, "", '0);

    // Writes landing during LOOKUP must not affect that lookup.
    do_req(10'h030, 32'h0000_0000, 0, 1'b1, "zed", 10'h030);
    do_req(10'h030, 32'h0000_0000, 0, 1'b0, "", '0);
    do_req(10'h030, 32'h0000_0000, 0, 1'b1, "new", 10'h030);
    do_req(10'h030, 32'h0000_0000, 0, 1'b0, "", '0);
    write_label("", 10'h3FF);
    do_req(10'h001, 32'hFFFF_FFFE, 1, 1'b0, "", '0);

    for (int i = 0; i < 9; i++) write_label("x", PW'(10'h100 + i));
    do_req(10'h100, 32'h0000_0000, 0, 1'b0, "", '0);
    do_req(10'h200, 32'hFFFF_FF01, 0, 1'b0, "", '0);

    // Reset while a letter is on the bus aborts and empties the table.
    write_label("loop", 10'h010);
    req_valid = 1'b1; req_pc = 10'h018; req_offset = 32'hFFFF_FFF8;
    tick();
    req_valid = 1'b0; char_ready = 1'b1;
    tick();
    tick();
    chk("mid_letter", char_out, 8'h6C);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    char_ready = 1'b0;
    model.delete();
    chk("abort_valid", char_valid, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_char", char_out, 0);
    do_req(10'h018, 32'hFFFF_FFF8, 0, 1'b0, "", '0);

    for (int it = 0; it < 40; it++) begin
      int            nw = $urandom_range(0, 3);
      int            tgt, off;
      logic [PW-1:0] rpc;
      for (int w = 0; w < nw; w++) begin
        txt_t t = '0;
        int   len = $urandom_range(0, NLET);
        for (int k = 0; k < len; k++) t[k] = 8'(8'h61 + $urandom_range(0, 25));
        drive_write(t, len, PW'($urandom_range(0, 15)));
        tick();
        label_we = 1'b0;
      end
      tgt = $urandom_range(0, 15);
      rpc = PW'($urandom);
      off = tgt - int'(rpc);
      if (off > 511) off -= 1024;
      if (off < -512) off += 1024;
      if ($urandom_range(0, 9) == 0) off = ($urandom_range(0, 1) != 0) ? 512 + $urandom_range(0, 999) : -513 - $urandom_range(0, 999);
      do_req(rpc, off, 1, ($urandom_range(0, 4) == 0), "qq", PW'(tgt));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
